// File: rtl/shader_scheduler.sv
// shader_scheduler: frame-level sequencer for the pixel_shader array.
//
// Each frame it resets the shaders, broadcasts every voxel for the rasterize
// pass, then broadcasts every voxel with its palette colour for the shade pass.
// Finally it walks pixel_index over all shaders and streams each pixel to the
// framebuffer writer.
//
// Optional feature macro: SHADER_SCHED_WATCHDOG_EN bounds every wait state by
// WATCHDOG_CYCLES and raises a sticky error flag when a wait times out.
//
// Handshake: a framebuffer transfer occurs on a rising clock edge where
// fb_valid && fb_ready. While fb_valid is high, fb_addr and fb_data do not
// change. fb_ready while fb_valid is low is ignored.
//
// Ports:
//   clock, reset (async, active-low)
//   start, voxel_count          : frame request, voxel count sampled at start
//   busy, frame_done, error     : status
//   voxel_rd/addr/data          : voxel memory (data valid 1 cycle after rd)
//   palette_addr/data           : palette RAM (1-cycle read latency)
//   voxel_x/y/z/id, palette_entry : registered broadcast bus to the shaders
//   shader_reset, do_rasterize, do_shade : shader controls
//   rasterizing_done, shading_done       : per-shader done pulses
//   pixel_index, pixel          : shared pixel readout bus
//   fb_valid/ready/addr/data    : framebuffer write handshake
//   state_dbg                   : current FSM state
module shader_scheduler #(
    parameter int NUM_SHADERS     = 16,
    parameter int VADDR_BITS      = 12,
    parameter int COORD_BITS      = 8,
    parameter int PALETTE_BITS    = 8,
    parameter int PIXEL_BITS      = 8,
    parameter int INDEX_BITS      = 32,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [VADDR_BITS-1:0]                 voxel_count,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  error,
    output logic                                  voxel_rd,
    output logic [VADDR_BITS-1:0]                 voxel_addr,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0]  voxel_data,
    output logic [PALETTE_BITS-1:0]               palette_addr,
    input  logic [PIXEL_BITS-1:0]                 palette_data,
    output logic [COORD_BITS-1:0]                 voxel_x,
    output logic [COORD_BITS-1:0]                 voxel_y,
    output logic [COORD_BITS-1:0]                 voxel_z,
    output logic [PALETTE_BITS-1:0]               voxel_id,
    output logic [PIXEL_BITS-1:0]                 palette_entry,
    output logic                                  shader_reset,
    output logic                                  do_rasterize,
    output logic                                  do_shade,
    input  logic [NUM_SHADERS-1:0]                rasterizing_done,
    input  logic [NUM_SHADERS-1:0]                shading_done,
    output logic [INDEX_BITS-1:0]                 pixel_index,
    input  logic [PIXEL_BITS-1:0]                 pixel,
    output logic                                  fb_valid,
    input  logic                                  fb_ready,
    output logic [INDEX_BITS-1:0]                 fb_addr,
    output logic [PIXEL_BITS-1:0]                 fb_data,
    output logic [3:0]                            state_dbg
);

    typedef enum logic [3:0] {
        IDLE, CLEAR, R_FETCH, R_LOAD, R_ISSUE, R_WAIT,
        S_FETCH, S_LOAD, S_PAL, S_ISSUE, S_WAIT, READOUT, FB_WAIT, DONE
    } state_t;

    state_t                  state, state_n;
    logic [VADDR_BITS-1:0]   count_q;
    logic [VADDR_BITS-1:0]   idx;
    logic [INDEX_BITS-1:0]   p;
    logic                    clr_cnt;
    logic [NUM_SHADERS-1:0]  done_seen;
    logic [NUM_SHADERS-1:0]  done_vec;
    logic                    all_done;
    logic                    wd_expire;
    logic                    wait_exit;
    logic                    fb_exit;
    logic                    idx_last;
    logic                    p_last;

    // Unpacked voxel word {id, z, y, x}
    logic [COORD_BITS-1:0]   vd_x, vd_y, vd_z;
    logic [PALETTE_BITS-1:0] vd_id;
    assign vd_x  = voxel_data[COORD_BITS-1:0];
    assign vd_y  = voxel_data[2*COORD_BITS-1:COORD_BITS];
    assign vd_z  = voxel_data[3*COORD_BITS-1:2*COORD_BITS];
    assign vd_id = voxel_data[3*COORD_BITS+PALETTE_BITS-1:3*COORD_BITS];

    // Done collection includes this cycle's pulses so a late ack exits at once.
    assign done_vec  = (state == S_WAIT) ? shading_done : rasterizing_done;
    assign all_done  = &(done_seen | done_vec);
    assign wait_exit = all_done | wd_expire;
    assign fb_exit   = fb_ready | wd_expire;
    // Compared against the latched count, so a full 2^VADDR_BITS-1 count works.
    assign idx_last  = ((idx + VADDR_BITS'(1)) == count_q);
    assign p_last    = ((p + INDEX_BITS'(1)) == INDEX_BITS'(NUM_SHADERS));

    assign pixel_index = p;
    assign state_dbg   = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n      = state;
        busy         = (state != IDLE);
        frame_done   = 1'b0;
        voxel_rd     = 1'b0;
        voxel_addr   = '0;
        palette_addr = '0;
        shader_reset = 1'b0;
        do_rasterize = 1'b0;
        do_shade     = 1'b0;
        fb_valid     = 1'b0;
        case (state)
            IDLE:    if (start) state_n = CLEAR;
            CLEAR: begin
                shader_reset = 1'b1;
                if (clr_cnt) state_n = (count_q == '0) ? READOUT : R_FETCH;
            end
            R_FETCH: begin
                voxel_rd   = 1'b1;
                voxel_addr = idx;
                state_n    = R_LOAD;
            end
            R_LOAD:  state_n = R_ISSUE;
            R_ISSUE: begin
                do_rasterize = 1'b1;
                state_n      = R_WAIT;
            end
            R_WAIT:  if (wait_exit) state_n = idx_last ? S_FETCH : R_FETCH;
            S_FETCH: begin
                voxel_rd   = 1'b1;
                voxel_addr = idx;
                state_n    = S_LOAD;
            end
            S_LOAD: begin
                // Palette address driven straight from the returning voxel so
                // the colour is back in S_PAL.
                palette_addr = vd_id;
                state_n      = S_PAL;
            end
            S_PAL:   state_n = S_ISSUE;
            S_ISSUE: begin
                do_shade = 1'b1;
                state_n  = S_WAIT;
            end
            S_WAIT:  if (wait_exit) state_n = idx_last ? READOUT : S_FETCH;
            READOUT: state_n = FB_WAIT;
            FB_WAIT: begin
                fb_valid = 1'b1;
                if (fb_exit) state_n = p_last ? DONE : READOUT;
            end
            DONE: begin
                frame_done = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q       <= '0;
            idx           <= '0;
            p             <= '0;
            clr_cnt       <= 1'b0;
            done_seen     <= '0;
            voxel_x       <= '0;
            voxel_y       <= '0;
            voxel_z       <= '0;
            voxel_id      <= '0;
            palette_entry <= '0;
            fb_addr       <= '0;
            fb_data       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    count_q <= voxel_count;
                    idx     <= '0;
                    p       <= '0;
                    clr_cnt <= 1'b0;
                end
                CLEAR: clr_cnt <= ~clr_cnt;
                R_LOAD, S_LOAD: begin
                    voxel_x  <= vd_x;
                    voxel_y  <= vd_y;
                    voxel_z  <= vd_z;
                    voxel_id <= vd_id;
                end
                S_PAL: palette_entry <= palette_data;
                R_ISSUE, S_ISSUE: done_seen <= '0;
                R_WAIT, S_WAIT: begin
                    done_seen <= done_seen | done_vec;
                    if (wait_exit) idx <= idx_last ? '0 : idx + VADDR_BITS'(1);
                end
                READOUT: begin
                    fb_addr <= p;
                    fb_data <= pixel;
                end
                FB_WAIT: if (fb_exit) p <= p_last ? '0 : p + INDEX_BITS'(1);
                default: ;
            endcase
        end
    end

`ifdef SHADER_SCHED_WATCHDOG_EN
    localparam int WD_BITS = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_BITS-1:0] wd_cnt;
    logic               in_wait;
    logic               normal_exit;

    assign in_wait     = (state == R_WAIT) || (state == S_WAIT) || (state == FB_WAIT);
    assign normal_exit = (state == FB_WAIT) ? fb_ready : all_done;
    assign wd_expire   = in_wait && (wd_cnt == WD_BITS'(WATCHDOG_CYCLES - 1));

    // Every wait is entered from a non-wait state, so clearing outside the
    // waits restarts the count on each entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            error  <= 1'b0;
        end else begin
            wd_cnt <= in_wait ? wd_cnt + WD_BITS'(1) : '0;
            if (state == IDLE && start)       error <= 1'b0;
            else if (wd_expire && !normal_exit) error <= 1'b1;
        end
    end
`else
    logic unused_wd;
    assign unused_wd = (WATCHDOG_CYCLES != 0);
    assign wd_expire = 1'b0;
    assign error     = 1'b0;
`endif

endmodule
